// File: rtl/seq_alu.sv
// Registered ALU with start/busy/done handshake, a shift-add multiplier and
// result-feedback ops (accumulate, shift) acting on the held result.
module seq_alu #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [2:0]         op,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned W2   = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [2:0] OpInc = 3'b000;
  localparam logic [2:0] OpAdd = 3'b001;
  localparam logic [2:0] OpLog = 3'b010;
  localparam logic [2:0] OpNz  = 3'b011;
  localparam logic [2:0] OpCat = 3'b100;
  localparam logic [2:0] OpMul = 3'b101;
  localparam logic [2:0] OpAcc = 3'b110;
  localparam logic [2:0] OpShl = 3'b111;

  localparam logic [W2-1:0]   One     = W2'(1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntLoad = CntW'(WIDTH);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StMul  = 2'b01
  } state_e;

  state_e r_state;
  state_e w_state_d;

  logic [W2-1:0]    r_result,  w_result_d;
  logic             r_done,    w_done_d;
  logic             r_busy,    w_busy_d;
  logic [W2-1:0]    r_mcand,   w_mcand_d;
  logic [WIDTH-1:0] r_mplier,  w_mplier_d;
  logic [W2-1:0]    r_product, w_product_d;
  logic [CntW-1:0]  r_cnt,     w_cnt_d;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_last;
  logic [W2-1:0]    w_a_ext;
  logic [W2-1:0]    w_b_ext;
  logic [W2-1:0]    w_prod_sum;
  logic [W2-1:0]    w_shl;
  logic [W2-1:0]    w_alu_res;

  assign w_accept = start && (r_state == StIdle);
  assign w_is_mul = (op == OpMul);
  assign w_last   = (r_cnt == CntOne);
  assign w_a_ext  = {{WIDTH{1'b0}}, A};
  assign w_b_ext  = {{WIDTH{1'b0}}, B};

  // Partial product added only when the current multiplier LSB is set.
  assign w_prod_sum = r_product + (r_mplier[0] ? r_mcand : '0);

  // Shifting by 2*WIDTH or more clears the result.
  assign w_shl = (32'(A) >= W2) ? '0 : (r_result << A);

  always_comb begin
    w_alu_res = '0;
    case (op)
      OpInc:   w_alu_res = w_a_ext + One;
      OpAdd:   w_alu_res = w_a_ext + w_b_ext;
      OpLog:   w_alu_res = {{WIDTH{1'b0}}, A | B, A ^ B} >> 0;
      OpNz:    w_alu_res = {{(W2-1){1'b0}}, |(A | B)};
      OpCat:   w_alu_res = {A, B};
      OpAcc:   w_alu_res = r_result + w_a_ext;
      OpShl:   w_alu_res = w_shl;
      default: w_alu_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept && w_is_mul) begin
          w_state_d = StMul;
        end
      end
      StMul: begin
        if (w_last) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Output and datapath next-state logic.
  always_comb begin
    w_result_d  = r_result;
    w_done_d    = 1'b0;
    w_mcand_d   = r_mcand;
    w_mplier_d  = r_mplier;
    w_product_d = r_product;
    w_cnt_d     = r_cnt;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_is_mul) begin
            w_mcand_d   = w_a_ext;
            w_mplier_d  = B;
            w_product_d = '0;
            w_cnt_d     = CntLoad;
          end else begin
            w_result_d = w_alu_res;
            w_done_d   = 1'b1;
          end
        end
      end
      StMul: begin
        w_product_d = w_prod_sum;
        w_mcand_d   = r_mcand << 1;
        w_mplier_d  = r_mplier >> 1;
        w_cnt_d     = r_cnt - CntOne;
        if (w_last) begin
          w_result_d = w_prod_sum;
          w_done_d   = 1'b1;
        end
      end
      default: ;
    endcase
    w_busy_d = (w_state_d == StMul);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_result  <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_product <= '0;
      r_cnt     <= '0;
    end else begin
      r_result  <= w_result_d;
      r_done    <= w_done_d;
      r_busy    <= w_busy_d;
      r_mcand   <= w_mcand_d;
      r_mplier  <= w_mplier_d;
      r_product <= w_product_d;
      r_cnt     <= w_cnt_d;
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=4): table of single-cycle vectors plus
// hand-written multiply, reset-abort and back-to-back sequences.
module tb_seq_alu;

  localparam int unsigned W = 4;

  logic             clock = 1'b0;
  logic             resetn;
  logic             start;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [2:0]       op;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   result;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  seq_alu #(.WIDTH(W)) dut (
    .clock (clock),
    .resetn(resetn),
    .A     (a),
    .B     (b),
    .op    (op),
    .start (start),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  typedef struct {
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic run_mul(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input logic [2*W-1:0] exp, input string tag);
    int lat;
    a = ma; b = mb; op = 3'b101; start = 1'b1;
    step();
    start = 1'b0;
    check({tag, " busy after accept"}, 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(W));
    check({tag, " result"}, 32'(result), 32'(exp));
    check({tag, " busy at done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{3'b000, 4'hF, 4'h0, 8'h10};
    vecs[1]  = '{3'b001, 4'h9, 4'h9, 8'h12};
    vecs[2]  = '{3'b010, 4'hA, 4'h5, 8'hFF};
    vecs[3]  = '{3'b011, 4'h0, 4'h0, 8'h00};
    vecs[4]  = '{3'b011, 4'h1, 4'h0, 8'h01};
    vecs[5]  = '{3'b100, 4'h3, 4'hC, 8'h3C};
    vecs[6]  = '{3'b001, 4'hF, 4'hF, 8'h1E};
    vecs[7]  = '{3'b010, 4'hC, 4'hA, 8'hE6};
    vecs[8]  = '{3'b100, 4'hF, 4'hE, 8'hFE};
    vecs[9]  = '{3'b110, 4'h3, 4'h0, 8'h01};
    vecs[10] = '{3'b111, 4'h3, 4'h0, 8'h08};
    vecs[11] = '{3'b111, 4'h8, 4'h0, 8'h00};
    vecs[12] = '{3'b000, 4'h0, 4'h0, 8'h01};
    vecs[13] = '{3'b111, 4'h7, 4'h0, 8'h80};
    vecs[14] = '{3'b110, 4'hF, 4'h0, 8'h8F};

    // Reset held with a multiply request pending.
    resetn = 1'b0; start = 1'b1; op = 3'b101; a = 4'h7; b = 4'h5;
    step();
    step();
    check("reset result", 32'(result), 32'h0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    resetn = 1'b1; start = 1'b0;
    step();
    step();
    check("idle after reset done", 32'(done), 32'd0);
    check("idle after reset result", 32'(result), 32'h0);
    check("idle after reset busy", 32'(busy), 32'd0);

    foreach (vecs[i]) begin
      a = vecs[i].a; b = vecs[i].b; op = vecs[i].op; start = 1'b1;
      step();
      start = 1'b0;
      check($sformatf("vec%0d result", i), 32'(result), 32'(vecs[i].exp));
      check($sformatf("vec%0d done", i), 32'(done), 32'd1);
      step();
      check($sformatf("vec%0d done drop", i), 32'(done), 32'd0);
      check($sformatf("vec%0d hold", i), 32'(result), 32'(vecs[i].exp));
    end

    // 15*15 with op=000 starts requested during busy; they must be dropped.
    a = 4'hF; b = 4'hF; op = 3'b101; start = 1'b1;
    step();
    check("mul busy after accept", 32'(busy), 32'd1);
    check("mul no early done", 32'(done), 32'd0);
    op = 3'b000; a = 4'h1;
    for (int i = 1; i <= int'(W); i++) begin
      start = (i < int'(W));
      step();
      if (i < int'(W)) begin
        check($sformatf("mul iter%0d busy", i), 32'(busy), 32'd1);
        check($sformatf("mul iter%0d done", i), 32'(done), 32'd0);
        check($sformatf("mul iter%0d result held", i), 32'(result), 32'h8F);
      end else begin
        check("mul final busy", 32'(busy), 32'd0);
        check("mul final done", 32'(done), 32'd1);
        check("mul final result", 32'(result), 32'hE1);
      end
    end
    step();
    check("mul no extra done", 32'(done), 32'd0);
    check("mul result kept", 32'(result), 32'hE1);
    check("mul idle busy", 32'(busy), 32'd0);

    // Reset two edges into a multiply aborts it.
    a = 4'h7; b = 4'h5; op = 3'b101; start = 1'b1;
    step();
    start = 1'b0;
    step();
    resetn = 1'b0;
    step();
    check("abort result", 32'(result), 32'h0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    resetn = 1'b1;
    step();
    run_mul(4'h7, 4'h5, 8'h23, "mul 7x5");
    run_mul(4'h0, 4'hF, 8'h00, "mul 0xF");
    run_mul(4'hF, 4'h1, 8'h0F, "mul Fx1");
    run_mul(4'hA, 4'hC, 8'h78, "mul AxC");

    // Clear result, then accumulate 1 on every edge with start held.
    a = 4'h0; b = 4'h0; op = 3'b100; start = 1'b1;
    step();
    check("b2b clear", 32'(result), 32'h0);
    op = 3'b110; a = 4'h1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("b2b acc%0d result", i), 32'(result), 32'(i));
      check($sformatf("b2b acc%0d done", i), 32'(done), 32'd1);
    end
    start = 1'b0;
    step();
    check("b2b done drop", 32'(done), 32'd0);
    check("b2b hold", 32'(result), 32'h5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Registered, parametrised ALU for the lab datapath. It extends the combinational 4-bit ALU in three ways: a generic operand width, a start/busy/done handshake, and a registered 2·WIDTH-bit result. It adds a multi-cycle shift-add multiplier and result-feedback operations (accumulate, shift). It sits between the switch/key input logic and the HEX/LEDR display decoders. The result register drives the displays directly.

## Interface
- WIDTH, 4, operand width in bits; must be ≥ 2.
- clock  in  1  rising-edge clock for all state.
- resetn  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
- A  in  WIDTH  operand A; captured at accepted start.
- B  in  WIDTH  operand B; captured at accepted start.
- op  in  3  operation select; captured at accepted start.
- start  in  1  request; level-sampled each edge.
- busy  out  1  high while a multiply is in progress.
- done  out  1  one-cycle pulse when result is updated.
- result  out  2·WIDTH  registered result; holds its value between operations.

## Operation
- States: IDLE and MUL.
- A start is accepted only in IDLE. A start seen in MUL is ignored and not queued.
- Operation codes. Results are zero-extended to 2·WIDTH unless stated otherwise.
  - 000: A+1, with the carry in bit WIDTH.
  - 001: A+B, with the carry in bit WIDTH.
  - 010: {A|B, A^B}.
  - 011: 1 if (A|B) ≠ 0, else 0.
  - 100: {A, B}.
  - 101: A·B, unsigned, using the multi-cycle shift-add path.
  - 110: result + A, mod 2^(2·WIDTH). This is an accumulate on the current result.
  - 111: result << A. A shift amount ≥ 2·WIDTH gives 0.
- Ops 000–100 and 110–111 are single-cycle. On the accepting edge, result is written, done is set, and the FSM stays in IDLE.
- Op 101 on the accepting edge:
  - mcand ← {0, A}, mplier ← B, product ← 0.
  - busy ← 1; go to MUL; load an iteration counter with WIDTH.
- Each edge in MUL:
  - If mplier[0] is 1, product ← product + mcand, mod 2^(2·WIDTH).
  - Then mcand ← mcand << 1, mplier ← mplier >> 1, and the counter decrements.
  - On the edge that consumes the last iteration: result ← final product, done ← 1, busy ← 0, return to IDLE.
- result changes only on done edges and on reset. The accumulate and shift ops use the pre-edge value of result.
- Reset has priority over everything and aborts a multiply in flight. After reset: result = 0, busy = 0, done = 0, FSM in IDLE, internal registers = 0.
- An undefined state recovers to IDLE.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Single-cycle ops: start sampled at edge k → result valid and done = 1 after edge k. done = 0 after edge k+1 unless a new start is accepted.
- Multiply: accepted at edge k → busy = 1 after edge k. Iterations occur at edges k+1 … k+WIDTH. result is valid, done = 1 and busy = 0 after edge k+WIDTH. Latency is WIDTH cycles.
- Back-to-back operation:
  - start held high in IDLE runs one op per cycle; done stays high for each completing op.
  - After a multiply, a new start is accepted at edge k+WIDTH+1 at the earliest.
- Changes to A, B or op after acceptance have no effect on an operation in flight.
- resetn low at edge k → all outputs at their reset values after edge k, regardless of state.

## Test plan
- Reset, WIDTH=4: hold resetn low for 2 edges with start=1 and op=101 → result=0x00, busy=0, done=0. Release → no operation until start is sampled high.
- Single-cycle ops:
  - A=0xF, op=000 → result=0x10 and done high for exactly 1 cycle.
  - A=9, B=9, op=001 → 0x12.
  - A=0xA, B=0x5, op=010 → 0xFF.
  - A=0, B=0, op=011 → 0x00.
  - A=3, B=0xC, op=100 → 0x3C.
- Multiply: A=0xF, B=0xF, op=101 → busy high for 4 cycles, result=0xE1 with done at edge k+4. A start with op=000 pulsed during busy is ignored: result stays 0xE1 and there is no extra done.
- Feedback ops:
  - From result=0xFE, op=110, A=3 → 0x01 (wrap).
  - From result=0x01, op=111, A=3 → 0x08.
  - Then op=111, A=8 → 0x00.
- Reset mid-operation: start op=101 with A=7, B=5, and assert resetn low at edge k+2 → result=0, busy=0, done=0 after that edge. A new op=101 with A=7, B=5 then yields 0x23.
- Back-to-back: start held high with op=110 and A=1 for 5 cycles from result=0 → result=1, 2, 3, 4, 5 on consecutive edges, with done continuously high.
